// File: rtl/wb_pkg.sv
// Shared encodings for the registered writeback stage: result sources,
// load sizes and the stage FSM states.
package wb_pkg;

    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC  = 2'b10;

    localparam logic [1:0] LD_B = 2'b00;
    localparam logic [1:0] LD_H = 2'b01;
    localparam logic [1:0] LD_W = 2'b10;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_pipe_load_align.sv
// Combinational load lane extraction: shifts the addressed byte/half lane of
// the memory word down to bit 0 and sign- or zero-extends it.
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OFF_W  = 1
) (
    input  logic              [DATA_W-1:0] mem_rd_data,
    input  logic              [1:0]        ld_size,
    input  logic                           ld_signed,
    input  logic              [OFF_W-1:0]  ld_off,
    output logic signed       [DATA_W-1:0] ld_word
);

    logic [OFF_W-1:0] off_h;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    function automatic logic signed [DATA_W-1:0] extend_b(input logic [7:0] v, input logic sgn);
        return {{(DATA_W-8){sgn & v[7]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] extend_h(input logic [15:0] v, input logic sgn);
        return {{(DATA_W-16){sgn & v[15]}}, v};
    endfunction

    // Misaligned halfword offsets are rounded down to the even lane.
    assign off_h  = ld_off & ~OFF_W'(1);
    assign lane_b = mem_rd_data[{ld_off, 3'b000} +: 8];
    assign lane_h = mem_rd_data[{off_h, 3'b000} +: 16];

    always_comb begin
        ld_word = mem_rd_data;
        case (ld_size)
            LD_B:    ld_word = extend_b(lane_b, ld_signed);
            LD_H:    ld_word = extend_h(lane_h, ld_signed);
            default: ld_word = mem_rd_data;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: accepts one retiring instruction per cycle,
// waits for late load data, and issues a one-cycle register-file write.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 3,
    parameter int ZERO_REG_RO = 0,
    parameter int RET_CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   src_sel,
    input  logic [1:0]                   ld_size,
    input  logic                         ld_signed,
    input  logic [$clog2(DATA_W/8)-1:0]  ld_off,
    input  logic [DATA_W-1:0]            alu_res,
    input  logic [DATA_W-1:0]            next_pc,
    input  logic [REG_AW-1:0]            rd_sel,
    input  logic                         rd_we,
    input  logic [DATA_W-1:0]            mem_rd_data,
    input  logic                         mem_rd_valid,
    input  logic                         flush,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic [REG_AW-1:0]            rf_waddr,
    output logic                         rf_we,
    output logic                         retire,
    output logic [RET_CNT_W-1:0]         ret_cnt
);

    localparam int OFF_W = $clog2(DATA_W/8);

    wb_state_t state;

    // Fields of an instruction parked while its load data is outstanding.
    logic [REG_AW-1:0] rd_sel_p1;
    logic              rd_we_p1;
    logic [1:0]        ld_size_p1;
    logic              ld_signed_p1;
    logic [OFF_W-1:0]  ld_off_p1;

    logic [1:0]                ald_size;
    logic                      ald_signed;
    logic [OFF_W-1:0]          ald_off;
    logic signed [DATA_W-1:0]  ld_word;

    logic                      accept;
    logic                      done;
    logic [REG_AW-1:0]         cmp_rd;
    logic                      cmp_we;
    logic [DATA_W-1:0]         cmp_data;
    logic                      wr_en;

    function automatic logic [DATA_W-1:0] sel_result(input logic [1:0] src,
                                                     input logic [DATA_W-1:0] alu,
                                                     input logic [DATA_W-1:0] pc,
                                                     input logic [DATA_W-1:0] mem);
        case (src)
            WB_SRC_MEM: return mem;
            WB_SRC_PC:  return pc;
            default:    return alu;
        endcase
    endfunction

    assign in_ready = (state == WB_IDLE);
    assign accept   = in_valid && in_ready && !flush;

    // While waiting, alignment follows the parked load, not the live inputs.
    always_comb begin
        ald_size   = ld_size;
        ald_signed = ld_signed;
        ald_off    = ld_off;
        if (state == WB_WAIT_MEM) begin
            ald_size   = ld_size_p1;
            ald_signed = ld_signed_p1;
            ald_off    = ld_off_p1;
        end
    end

    load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .mem_rd_data (mem_rd_data),
        .ld_size     (ald_size),
        .ld_signed   (ald_signed),
        .ld_off      (ald_off),
        .ld_word     (ld_word)
    );

    always_comb begin
        done     = 1'b0;
        cmp_rd   = rd_sel;
        cmp_we   = rd_we;
        cmp_data = sel_result(src_sel, alu_res, next_pc, ld_word);
        if (state == WB_WAIT_MEM) begin
            done     = mem_rd_valid && !flush;
            cmp_rd   = rd_sel_p1;
            cmp_we   = rd_we_p1;
            cmp_data = ld_word;
        end else begin
            done = accept && ((src_sel != WB_SRC_MEM) || mem_rd_valid);
        end
    end

    assign wr_en = done && cmp_we && !((ZERO_REG_RO != 0) && (cmp_rd == '0));

    // Stage boundary: completion registered into the register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WB_IDLE;
            rf_we        <= 1'b0;
            retire       <= 1'b0;
            rf_wdata     <= '0;
            rf_waddr     <= '0;
            ret_cnt      <= '0;
            rd_sel_p1    <= '0;
            rd_we_p1     <= 1'b0;
            ld_size_p1   <= '0;
            ld_signed_p1 <= 1'b0;
            ld_off_p1    <= '0;
        end else begin
            rf_we  <= wr_en;
            retire <= done;
            if (accept) begin
                rd_sel_p1    <= rd_sel;
                rd_we_p1     <= rd_we;
                ld_size_p1   <= ld_size;
                ld_signed_p1 <= ld_signed;
                ld_off_p1    <= ld_off;
            end
            if (wr_en) begin
                rf_wdata <= cmp_data;
                rf_waddr <= cmp_rd;
            end
            if (done) begin
                ret_cnt <= ret_cnt + RET_CNT_W'(1);
            end
            case (state)
                WB_IDLE: begin
                    if (accept && (src_sel == WB_SRC_MEM) && !mem_rd_valid) begin
                        state <= WB_WAIT_MEM;
                    end
                end
                WB_WAIT_MEM: begin
                    if (flush || mem_rd_valid) begin
                        state <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe: expected writes are queued when an
// instruction is driven and checked when the stage retires it.
module tb_wb_stage_pipe;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    src_sel;
    logic [1:0]    ld_size;
    logic          ld_signed;
    logic [0:0]    ld_off;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] next_pc;
    logic [AW-1:0] rd_sel;
    logic          rd_we;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_valid;
    logic          flush;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rf_waddr;
    logic          rf_we;
    logic          retire;
    logic [CW-1:0] ret_cnt;

    wb_stage_pipe #(
        .DATA_W      (DW),
        .REG_AW      (AW),
        .ZERO_REG_RO (1),
        .RET_CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .src_sel      (src_sel),
        .ld_size      (ld_size),
        .ld_signed    (ld_signed),
        .ld_off       (ld_off),
        .alu_res      (alu_res),
        .next_pc      (next_pc),
        .rd_sel       (rd_sel),
        .rd_we        (rd_we),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .flush        (flush),
        .rf_wdata     (rf_wdata),
        .rf_waddr     (rf_waddr),
        .rf_we        (rf_we),
        .retire       (retire),
        .ret_cnt      (ret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            cyc     = 0;
    int            n_vec   = 0;
    int            n_err   = 0;
    logic [CW-1:0] mdl_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic expect_wr(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.cyc  = cyc + 1;
        e.we   = we;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("retire", 32'(retire), 32'd1);
            chk("rf_we", 32'(rf_we), 32'(e.we));
            if (e.we) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
                chk("rf_wdata", 32'(rf_wdata), 32'(e.data));
            end
            mdl_cnt++;
        end else begin
            chk("retire_idle", 32'(retire), 32'd0);
            chk("rf_we_idle", 32'(rf_we), 32'd0);
        end
        chk("ret_cnt", 32'(ret_cnt), 32'(mdl_cnt));
    endtask

    task automatic idle_in();
        in_valid     = 1'b0;
        src_sel      = 2'b00;
        ld_size      = 2'b00;
        ld_signed    = 1'b0;
        ld_off       = 1'b0;
        alu_res      = '0;
        next_pc      = '0;
        rd_sel       = '0;
        rd_we        = 1'b0;
        mem_rd_data  = '0;
        mem_rd_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic op(input logic [1:0] src, input logic [DW-1:0] alu, input logic [DW-1:0] pc,
                      input logic [AW-1:0] rd, input logic we);
        in_valid = 1'b1;
        src_sel  = src;
        alu_res  = alu;
        next_pc  = pc;
        rd_sel   = rd;
        rd_we    = we;
    endtask

    function automatic logic [DW-1:0] ref_align(input logic [DW-1:0] d, input logic [1:0] sz,
                                                input logic sg, input logic of);
        logic [7:0] b;
        if (sz == 2'b00) begin
            b = of ? d[15:8] : d[7:0];
            return (sg && b[7]) ? {8'hff, b} : {8'h00, b};
        end
        // A 16-bit word holds one halfword lane, so halves and words both pass d.
        return d;
    endfunction

    logic [DW-1:0] d;
    logic [1:0]    sz;
    logic          sg;
    logic          of;
    logic [AW-1:0] r;
    int            lat;

    initial begin
        idle_in();
        rst = 1'b1;
        sb.delete();
        mdl_cnt = '0;
        tick();
        tick();
        chk("rst_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Back-to-back ALU results
        op(2'b00, 16'h1234, 16'h0, 3'd3, 1'b1);
        expect_wr(1'b1, 3'd3, 16'h1234);
        tick();
        chk("rdy_b2b0", 32'(in_ready), 32'd1);
        op(2'b00, 16'h00ff, 16'h0, 3'd5, 1'b1);
        expect_wr(1'b1, 3'd5, 16'h00ff);
        tick();
        chk("rdy_b2b1", 32'(in_ready), 32'd1);
        idle_in();
        tick();
        chk("cnt_b2b", 32'(ret_cnt), 32'd2);

        // JAL link and the alternate ALU encoding
        op(2'b10, 16'hdead, 16'h0042, 3'd7, 1'b1);
        expect_wr(1'b1, 3'd7, 16'h0042);
        tick();
        op(2'b11, 16'h5a5a, 16'h1111, 3'd1, 1'b1);
        expect_wr(1'b1, 3'd1, 16'h5a5a);
        tick();
        // No-write instruction and write to r0 both retire without a write
        op(2'b00, 16'h3333, 16'h0, 3'd6, 1'b0);
        expect_wr(1'b0, 3'd6, 16'h3333);
        tick();
        op(2'b00, 16'h7777, 16'h0, 3'd0, 1'b1);
        expect_wr(1'b0, 3'd0, 16'h7777);
        tick();
        idle_in();
        tick();
        chk("hold_wdata", 32'(rf_wdata), 32'h5a5a);
        chk("hold_waddr", 32'(rf_waddr), 32'd1);

        // Byte loads with data in the accepting cycle
        op(2'b01, 16'h0, 16'h0, 3'd2, 1'b1);
        ld_size = 2'b00; ld_off = 1'b1; ld_signed = 1'b1;
        mem_rd_data = 16'h80a5; mem_rd_valid = 1'b1;
        expect_wr(1'b1, 3'd2, 16'hff80);
        tick();
        ld_signed = 1'b0;
        expect_wr(1'b1, 3'd2, 16'h0080);
        tick();
        idle_in();
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'h1357;
        tick();
        idle_in();

        // Late load: three stall cycles, younger instruction held off
        op(2'b01, 16'h0, 16'h0, 3'd4, 1'b1);
        ld_size = 2'b10; mem_rd_data = 16'h1111; mem_rd_valid = 1'b0;
        tick();
        chk("rdy_wait0", 32'(in_ready), 32'd0);
        op(2'b00, 16'h9999, 16'h0, 3'd6, 1'b1);
        ld_size = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdy_wait", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'hbeef;
        expect_wr(1'b1, 3'd4, 16'hbeef);
        tick();
        chk("rdy_after_late", 32'(in_ready), 32'd1);
        idle_in();
        tick();

        // Flush beats simultaneous data in WAIT_MEM
        op(2'b01, 16'h0, 16'h0, 3'd5, 1'b1);
        ld_size = 2'b10;
        tick();
        chk("rdy_flushw", 32'(in_ready), 32'd0);
        in_valid = 1'b0; flush = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 16'hcafe;
        tick();
        chk("rdy_flush", 32'(in_ready), 32'd1);
        idle_in();
        tick();
        // Flush in IDLE blocks the accept
        op(2'b00, 16'h4444, 16'h0, 3'd3, 1'b1);
        flush = 1'b1;
        tick();
        chk("rdy_flushi", 32'(in_ready), 32'd1);
        idle_in();
        tick();

        // Random loads, each with 0..2 stall cycles
        for (int i = 0; i < 8; i++) begin
            d   = 16'($urandom);
            sz  = 2'($urandom_range(0, 2));
            sg  = 1'($urandom_range(0, 1));
            of  = 1'($urandom_range(0, 1));
            r   = 3'($urandom_range(1, 7));
            lat = $urandom_range(0, 2);
            op(2'b01, 16'h0, 16'h0, r, 1'b1);
            ld_size = sz; ld_signed = sg; ld_off = of;
            if (lat == 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = d;
                expect_wr(1'b1, r, ref_align(d, sz, sg, of));
                tick();
            end else begin
                mem_rd_valid = 1'b0;
                mem_rd_data  = ~d;
                tick();
                in_valid = 1'b0;
                ld_size = ~sz; ld_signed = ~sg; ld_off = ~of; rd_sel = 3'd0;
                for (int w = 1; w < lat; w++) tick();
                mem_rd_valid = 1'b1;
                mem_rd_data  = d;
                expect_wr(1'b1, r, ref_align(d, sz, sg, of));
                tick();
            end
            idle_in();
        end
        tick();

        // Reset while waiting for memory
        op(2'b01, 16'h0, 16'h0, 3'd3, 1'b1);
        ld_size = 2'b10;
        tick();
        idle_in();
        rst = 1'b1;
        sb.delete();
        mdl_cnt = '0;
        tick();
        chk("rstw_wdata", 32'(rf_wdata), 32'd0);
        chk("rstw_waddr", 32'(rf_waddr), 32'd0);
        chk("rstw_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'hface;
        tick();
        idle_in();

        // Sixteen retires wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) begin
            op(2'b00, 16'(i * 3 + 1), 16'h0, 3'(i % 7 + 1), 1'b1);
            expect_wr(1'b1, 3'(i % 7 + 1), 16'(i * 3 + 1));
            tick();
        end
        idle_in();
        tick();
        chk("cnt_wrap", 32'(ret_cnt), 32'd0);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Parametrised, registered writeback stage. Replaces the purely combinational writeback mux.
- Sits between the memory stage and the register file.
- Accepts one retiring instruction per cycle through a valid/ready handshake, selects the result source, and aligns and extends sub-word load data.
- Waits for late memory read data, supports flush, and issues a single-cycle register-file write plus a retired-instruction count.

Parameters:
- DATA_W, 16, datapath width in bits; a multiple of 8, at least 16.
- REG_AW, 3, register-address width.
- ZERO_REG_RO, 0, when 1, writes to register 0 are suppressed (rf_we stays 0) but still counted as retired.
- RET_CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- src_sel  in  2  result source: 00 ALU, 01 MEM, 10 next_pc (JAL link), 11 ALU.
- ld_size  in  2  00 byte, 01 half, 10/11 full word.
- ld_signed  in  1  sign-extend sub-word loads when 1, zero-extend when 0.
- ld_off  in  $clog2(DATA_W/8)  byte offset of the load within the word.
- alu_res  in  DATA_W  ALU result.
- next_pc  in  DATA_W  PC+step for link.
- rd_sel  in  REG_AW  destination register.
- rd_we  in  1  instruction writes a register.
- mem_rd_data  in  DATA_W  memory read word.
- mem_rd_valid  in  1  mem_rd_data valid this cycle.
- flush  in  1  discard the pending instruction.
- rf_wdata  out  DATA_W  register-file write data.
- rf_waddr  out  REG_AW  register-file write address.
- rf_we  out  1  one-cycle write strobe.
- retire  out  1  one-cycle pulse per completed instruction.
- ret_cnt  out  RET_CNT_W  retired-instruction count.

Behaviour:
- States: IDLE and WAIT_MEM.
- Reset (sync, takes priority over all inputs):
  - state=IDLE.
  - rf_we=0, retire=0, rf_wdata=0, rf_waddr=0, ret_cnt=0.
  - Held instruction fields cleared.
- Accept: on a rising edge with in_valid && in_ready && !flush. The instruction fields are captured.
- Non-MEM source (src_sel!=01):
  - Completes at the accepting edge.
  - rf_we=rd_we (masked by ZERO_REG_RO when rd_sel==0), retire=1, rf_wdata=selected value, rf_waddr=rd_sel, all valid in cycle N+1.
  - Latency is 1 cycle; throughput is 1 instruction per cycle.
- MEM source with mem_rd_valid=1 in the accepting cycle: completes exactly as above, using the aligned load data.
- MEM source with mem_rd_valid=0: state goes to WAIT_MEM and in_ready=0. Outputs carry rf_we=0 and retire=0.
- WAIT_MEM:
  - On the first cycle with mem_rd_valid=1: completes at that edge (write in the following cycle) and returns to IDLE.
  - in_ready rises in the cycle after completion.
  - The stall length is unbounded.
- Flush:
  - In IDLE, flush blocks the accept in that cycle.
  - In WAIT_MEM, flush returns the stage to IDLE with no write and no retire.
  - If flush and mem_rd_valid are simultaneous in WAIT_MEM, flush wins.
- mem_rd_valid in IDLE with no MEM accept is ignored.
- rf_we and retire are single-cycle pulses. rf_wdata and rf_waddr hold their last value when rf_we=0.
- Load alignment:
  - The selected lane is shifted to bit 0.
  - Byte: lane = ld_off.
  - Half: lane = ld_off with bit 0 forced to 0 (misaligned halves are rounded down, with no trap).
  - Extension fills the upper bits with the lane MSB when ld_signed=1, else with 0.
  - Full word passes through unchanged; ld_off is ignored.
- Counter: ret_cnt increments by 1 on each retire. It wraps modulo 2^RET_CNT_W with no saturation.

Decomposition:
- Package wb_pkg: the src_sel encodings (WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC), the ld_size encodings (LD_B, LD_H, LD_W), and the state enum wb_state_t.
- Sub-module load_align (combinational): mem_rd_data, ld_size, ld_signed and ld_off in, extended word out.
- FSM, capture registers and counter stay in wb_stage_pipe.

Test Plan:
- Back-to-back ALU ops: alu_res=0x1234 to r3, then 0x00FF to r5 on consecutive cycles → rf_we high two consecutive cycles with data/addr matching; in_ready stays 1; ret_cnt goes 0→2.
- JAL: src_sel=10, next_pc=0x0042, rd_sel=7 → next cycle rf_wdata=0x0042, rf_waddr=7, rf_we=1.
- Signed byte load, data returned in the same cycle: mem_rd_data=0x80A5, ld_size=00, ld_off=1, ld_signed=1 → rf_wdata=0xFF80. Repeated with ld_signed=0 → 0x0080.
- Late load: MEM accept with mem_rd_valid=0, then valid after 3 cycles with 0xBEEF (full word) → in_ready=0 for 4 cycles, a single rf_we pulse with 0xBEEF, then in_ready=1.
- Flush during WAIT_MEM, with mem_rd_valid asserted in the same cycle → no rf_we, no retire, ret_cnt unchanged, IDLE next cycle.
- Reset asserted in WAIT_MEM, plus counter wrap with RET_CNT_W=4 → all outputs 0 next cycle; 16 retires bring ret_cnt back to 0.
